hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Producer-side companion to the execute-stage forwarding unit.
- Tracks destination registers of in-flight long-latency ops (loads, mul/div) whose results cannot be forwarded from MEM/WB in time.
- Raises a decode-stage stall on RAW or WAW conflicts against those registers.
- Clears entries when the long-latency result is written back.

Parameters:
- MAX_OUTSTANDING, 4, max simultaneously pending long-latency ops (1..31).
- CNT_W, 3, width of outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- rs1_addr_decode  input  5  decode-stage source 1 address
- rs1_used_decode  input  1  instruction reads rs1
- rs2_addr_decode  input  5  decode-stage source 2 address
- rs2_used_decode  input  1  instruction reads rs2
- rd_addr_decode  input  5  decode-stage destination address
- rd_write_decode  input  1  instruction writes rd
- long_latency_decode  input  1  instruction is load/mul/div
- issue_valid  input  1  decode instruction advances to execute this cycle (already qualified by stall, see below)
- flush_decode  input  1  decode instruction squashed (branch/jump redirect)
- done_valid  input  1  long-latency result written back this cycle
- done_addr  input  5  register being completed
- stall_decode  output  1  hold PC/IF/ID, insert bubble into EX
- pending_mask  output  32  current pending bits, bit 0 always 0
- outstanding_cnt  output  CNT_W  number of set pending bits
- sb_error  output  1  sticky: completion to a non-pending register

Behaviour:
- Reset (async, rst=1): pending_mask=0, outstanding_cnt=0, sb_error=0. stall_decode=0 while in reset.
- State: 32-bit pending register, CNT_W counter, sticky error flop. All update on rising clk.
- Set condition: issue_valid & ~flush_decode & rd_write_decode & long_latency_decode & rd_addr_decode!=0 & ~stall_decode.
- Clear condition: done_valid & done_addr!=0 & pending[done_addr].
- Same-cycle set and clear of the same register: set wins and the counter is unchanged. Same-cycle set and clear of different registers: counter unchanged. Set only: +1. Clear only: -1.
- done_valid with done_addr=0: ignored, no error.
- done_valid on a non-pending, nonzero register: no state change except sb_error<=1. sb_error holds until rst.
- stall_decode is combinational from registered state plus decode inputs. It asserts when any of:
  - RAW: rs1_used_decode & rs1_addr_decode!=0 & pending[rs1_addr_decode]; same for rs2.
  - WAW: rd_write_decode & rd_addr_decode!=0 & pending[rd_addr_decode].
  - Full: long_latency_decode & rd_write_decode & outstanding_cnt==MAX_OUTSTANDING.
- flush_decode=1 forces stall_decode=0; a squashed instruction never stalls and never sets.
- Latency: set at edge N is visible in pending_mask/stall from cycle N+1. A clear at edge N releases the stall in cycle N+1 (without the optional bypass).
- A set attempted while stall_decode=1 is ignored, so the counter cannot overflow. The upstream issue_valid must not be high during stall; if it is, it is masked.
- Short-latency ops never touch the scoreboard; the forwarding unit covers them.
- Reset mid-operation discards all pending entries. Any completions arriving after reset are ignored and set sb_error if nonzero.

Optional Feature:
- Macro: SB_DONE_BYPASS_EN.
- Defined: a register matching done_addr with done_valid=1 in the current cycle is treated as not pending for the RAW/WAW stall terms in that same cycle. The full term also sees the count after the same-cycle clear. Releases the stall one cycle earlier; it relies on the register file write-before-read or the WB forward path.
- Undefined: stall terms use only the registered pending bits and count; one extra stall cycle after completion.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle with pending_mask=0x0000_0020 -> pending_mask=0, outstanding_cnt=0, sb_error=0 immediately, before the next clk edge.
- Load-use RAW: issue load rd=x5 at edge 0; next cycle decode rs1=x5, rs1_used=1 -> stall_decode=1. Then done_valid, done_addr=5 at edge 3 -> stall_decode=0 in cycle 4, or in cycle 3 with SB_DONE_BYPASS_EN.
- WAW and x0: issue load rd=x7; decode writes rd=x7 -> stall=1. Issue load rd=x0 -> no pending bit, outstanding_cnt unchanged.
- Full: MAX_OUTSTANDING=4, issue loads to x1..x4 -> cnt=4. A fifth load to x9 stalls; an ALU op to x9 with no pending sources does not. Completing x2 -> the fifth load issues, cnt stays 4.
- Simultaneous events and error: same cycle complete x3 and issue load rd=x3 (bypass build) -> pending[3]=1, cnt unchanged. Separately, done_addr=12 not pending -> sb_error=1, held across further traffic.
- Flush: decode load rd=x6 with flush_decode=1, issue_valid=1, rs1=pending x1 -> stall_decode=0, pending[6] remains 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW/full stall scoreboard for long-latency ops (loads, mul/div).
// Define SB_DONE_BYPASS_EN to let a same-cycle writeback release the stall one cycle early.
module hazard_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_addr_decode,
  input  logic             rs1_used_decode,
  input  logic [4:0]       rs2_addr_decode,
  input  logic             rs2_used_decode,
  input  logic [4:0]       rd_addr_decode,
  input  logic             rd_write_decode,
  input  logic             long_latency_decode,
  input  logic             issue_valid,
  input  logic             flush_decode,
  input  logic             done_valid,
  input  logic [4:0]       done_addr,
  output logic             stall_decode,
  output logic [31:0]      pending_mask,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             sb_error
);

  localparam int unsigned NREG = 32;

  logic [NREG-1:0]  pending_q;
  logic [CNT_W-1:0] cnt_q;
  logic             error_q;

  logic [NREG-1:0]  done_onehot;
  logic [NREG-1:0]  rd_onehot;
  logic             clr_hit;
  logic             err_hit;
  logic             set_hit;
  logic [NREG-1:0]  pend_view;
  logic [CNT_W-1:0] cnt_view;
  logic             raw_hit;
  logic             waw_hit;
  logic             full_hit;

  assign done_onehot = NREG'(1) << done_addr;
  assign rd_onehot   = NREG'(1) << rd_addr_decode;

  // Completion bookkeeping: clear a pending entry, or flag a stray completion.
  assign clr_hit = done_valid & (done_addr != 5'd0) &  pending_q[done_addr];
  assign err_hit = done_valid & (done_addr != 5'd0) & ~pending_q[done_addr];

  // View of pending state used by the stall terms.
`ifdef SB_DONE_BYPASS_EN
  assign pend_view = pending_q & ~(clr_hit ? done_onehot : '0);
  assign cnt_view  = cnt_q - CNT_W'(clr_hit);
`else
  assign pend_view = pending_q;
  assign cnt_view  = cnt_q;
`endif

  always_comb begin
    raw_hit  = 1'b0;
    waw_hit  = 1'b0;
    full_hit = 1'b0;
    if (rs1_used_decode && (rs1_addr_decode != 5'd0) && pend_view[rs1_addr_decode])
      raw_hit = 1'b1;
    if (rs2_used_decode && (rs2_addr_decode != 5'd0) && pend_view[rs2_addr_decode])
      raw_hit = 1'b1;
    if (rd_write_decode && (rd_addr_decode != 5'd0) && pend_view[rd_addr_decode])
      waw_hit = 1'b1;
    if (long_latency_decode && rd_write_decode && (cnt_view == CNT_W'(MAX_OUTSTANDING)))
      full_hit = 1'b1;
  end

  // A squashed instruction never stalls; nothing stalls while held in reset.
  assign stall_decode = (raw_hit | waw_hit | full_hit) & ~flush_decode & ~rst;

  // Issue is masked by our own stall, so the counter can never exceed the limit.
  assign set_hit = issue_valid & ~flush_decode & rd_write_decode & long_latency_decode &
                   (rd_addr_decode != 5'd0) & ~stall_decode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      // Set wins over a same-cycle clear of the same register.
      pending_q <= ((pending_q & ~(clr_hit ? done_onehot : '0)) |
                    (set_hit ? rd_onehot : '0)) & ~NREG'(1);
      case ({set_hit, clr_hit})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (err_hit)
        error_q <= 1'b1;
    end
  end

  assign pending_mask    = pending_q;
  assign outstanding_cnt = cnt_q;
  assign sb_error        = error_q;

endmodule
